// File: rtl/cache_level_2_if.sv
// Word-serial main-memory bus between the L2 cache (master) and main memory (slave).
// A strobe (mm_read or mm_write) is held until the beat where mm_ready is high.
interface cache_level_2_if #(
    parameter int MM_AW = 32
);
    logic [MM_AW-1:0] mm_addr;
    logic [31:0]      mm_wdata;
    logic             mm_read;
    logic             mm_write;
    logic             mm_ready;
    logic [31:0]      mm_rdata;

    modport master (
        output mm_addr, mm_wdata, mm_read, mm_write,
        input  mm_ready, mm_rdata
    );

    modport slave (
        input  mm_addr, mm_wdata, mm_read, mm_write,
        output mm_ready, mm_rdata
    );
endinterface

// File: rtl/cache_level_2.sv
// Direct-mapped, write-through / no-write-allocate L2 cache serving 128-bit blocks to L1.
// Optional hit/miss counters are enabled by defining the macro L2_STATS_EN.
module cache_level_2 #(
    parameter int INDEX_W = 6,
    parameter int MM_AW   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         addr_to_mem,
    input  logic [31:0]         data_to_mem,
    input  logic                mem_read_index,
    input  logic                mem_write_index,
    output logic                stall_level_2,
    output logic [127:0]        block_of_data_from_cache_level_2,
    cache_level_2_if.master     mm
`ifdef L2_STATS_EN
    ,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
`endif
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 30 - INDEX_W;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, WDONE} state_t;

    state_t state, state_next;

    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tag_ram  [LINES];
    logic [127:0]       data_ram [LINES];

    logic [31:0]        lat_addr;
    logic [31:0]        lat_data;
    logic [1:0]         cnt;
    logic [127:0]       line_buf;

    logic [TAG_W-1:0]   req_tag, lat_tag;
    logic [INDEX_W-1:0] req_index, lat_index;
    logic [1:0]         lat_word;
    logic               hit, lat_hit;

    logic               fill_start, write_start, beat, line_write, write_done;

    assign req_tag   = addr_to_mem[31:INDEX_W+2];
    assign req_index = addr_to_mem[INDEX_W+1:2];
    assign lat_tag   = lat_addr[31:INDEX_W+2];
    assign lat_index = lat_addr[INDEX_W+1:2];
    assign lat_word  = lat_addr[1:0];

    assign hit     = valid[req_index] && (tag_ram[req_index] == req_tag);
    assign lat_hit = valid[lat_index] && (tag_ram[lat_index] == lat_tag);

    assign block_of_data_from_cache_level_2 = data_ram[req_index];

    // Read wins over write in IDLE; WDONE gives L1 one unstalled cycle and ignores requests.
    always_comb begin
        state_next    = state;
        stall_level_2 = 1'b0;
        fill_start    = 1'b0;
        write_start   = 1'b0;
        beat          = 1'b0;
        line_write    = 1'b0;
        write_done    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read_index) begin
                    if (!hit) begin
                        stall_level_2 = 1'b1;
                        fill_start    = 1'b1;
                        state_next    = FILL;
                    end
                end else if (mem_write_index) begin
                    stall_level_2 = 1'b1;
                    write_start   = 1'b1;
                    state_next    = WRITE;
                end
            end
            FILL: begin
                stall_level_2 = 1'b1;
                if (mm.mm_ready) begin
                    beat = 1'b1;
                    if (cnt == 2'd3) begin
                        line_write = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            WRITE: begin
                stall_level_2 = 1'b1;
                if (mm.mm_ready) begin
                    write_done = 1'b1;
                    state_next = WDONE;
                end
            end
            WDONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Strobes are registered so they only move on clock edges; the request is latched
    // so the operation completes even if L1 drops it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            valid       <= '0;
            cnt         <= 2'd0;
            lat_addr    <= '0;
            lat_data    <= '0;
            line_buf    <= '0;
            mm.mm_read  <= 1'b0;
            mm.mm_write <= 1'b0;
            mm.mm_addr  <= '0;
            mm.mm_wdata <= '0;
        end else begin
            state <= state_next;
            if (fill_start) begin
                lat_addr   <= addr_to_mem;
                cnt        <= 2'd0;
                mm.mm_read <= 1'b1;
                mm.mm_addr <= MM_AW'({addr_to_mem[31:2], 2'b00});
            end
            if (write_start) begin
                lat_addr    <= addr_to_mem;
                lat_data    <= data_to_mem;
                mm.mm_write <= 1'b1;
                mm.mm_addr  <= MM_AW'(addr_to_mem);
                mm.mm_wdata <= data_to_mem;
            end
            if (beat) begin
                line_buf[{cnt, 5'd0} +: 32] <= mm.mm_rdata;
                cnt <= cnt + 2'd1;
                if (cnt == 2'd3) begin
                    mm.mm_read       <= 1'b0;
                    valid[lat_index] <= 1'b1;
                end else begin
                    mm.mm_addr <= MM_AW'({lat_addr[31:2], cnt + 2'd1});
                end
            end
            if (write_done) begin
                mm.mm_write <= 1'b0;
            end
        end
    end

    // Line storage has no reset; the valid bits alone decide what is resident.
    always_ff @(posedge clk) begin
        if (line_write) begin
            data_ram[lat_index] <= {mm.mm_rdata, line_buf[95:0]};
            tag_ram[lat_index]  <= lat_tag;
        end else if (write_done && lat_hit) begin
            data_ram[lat_index][{lat_word, 5'd0} +: 32] <= lat_data;
        end
    end

`ifdef L2_STATS_EN
    logic after_fill;

    // The hit seen right after a refill completes belongs to the miss, not a new hit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            after_fill <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            after_fill <= line_write;
            if (state == IDLE && mem_read_index && hit && !after_fill) begin
                hit_count <= hit_count + 32'd1;
            end
            if (fill_start) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_level_2.sv
// Self-checking bench for cache_level_2: vector table plus reset and drop corner cases,
// with a memory model and a scoreboard of expected memory beats.
module tb_cache_level_2;

    logic         clk;
    logic         rst;
    logic [31:0]  addr_to_mem;
    logic [31:0]  data_to_mem;
    logic         mem_read_index;
    logic         mem_write_index;
    logic         stall_level_2;
    logic [127:0] block_of_data_from_cache_level_2;
`ifdef L2_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    cache_level_2_if #(.MM_AW(32)) mm_bus ();

    cache_level_2 #(.INDEX_W(6), .MM_AW(32)) dut (
        .clk                              (clk),
        .rst                              (rst),
        .addr_to_mem                      (addr_to_mem),
        .data_to_mem                      (data_to_mem),
        .mem_read_index                   (mem_read_index),
        .mem_write_index                  (mem_write_index),
        .stall_level_2                    (stall_level_2),
        .block_of_data_from_cache_level_2 (block_of_data_from_cache_level_2),
        .mm                               (mm_bus)
`ifdef L2_STATS_EN
        ,
        .hit_count                        (hit_count),
        .miss_count                       (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic         rd;
        logic         wr;
        int           wait_cyc;
        logic         exp_miss;
        logic         drop_early;
        logic         check_block;
        logic [127:0] exp_block;
    } vec_t;

    typedef struct {
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    localparam int BUDGET = 200;

    int compares = 0;
    int fails    = 0;

    beat_t       exp_q [$];
    vec_t        vecs [$];
    logic [31:0] mem_store [logic [31:0]];

    // Untouched memory words read back as their address xor 0x50 (0x40..0x43 -> 0x10..0x13).
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return a ^ 32'h0000_0050;
    endfunction

    function automatic vec_t mk(input string name, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic rd, input logic wr,
                                input int wait_cyc, input logic exp_miss,
                                input logic drop_early, input logic check_block,
                                input logic [127:0] exp_block);
        vec_t v;
        v.name = name; v.addr = addr; v.wdata = wdata; v.rd = rd; v.wr = wr;
        v.wait_cyc = wait_cyc; v.exp_miss = exp_miss; v.drop_early = drop_early;
        v.check_block = check_block; v.exp_block = exp_block;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        compares++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Serve one memory cycle: assert mm_ready when the strobe has waited long enough.
    task automatic serveMemory(input string name, input int wait_cyc, inout int strobe_cnt);
        beat_t e;
        mm_bus.mm_ready = 1'b0;
        if (mm_bus.mm_read || mm_bus.mm_write) begin
            strobe_cnt++;
            if (strobe_cnt > wait_cyc) begin
                strobe_cnt = 0;
                mm_bus.mm_ready = 1'b1;
                mm_bus.mm_rdata = mem_rd(mm_bus.mm_addr);
                if (exp_q.size() == 0) begin
                    checkOutput({name, " unexpected beat"}, 128'(mm_bus.mm_addr), 128'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput({name, " beat kind"}, 128'(mm_bus.mm_write), 128'(e.is_write));
                    checkOutput({name, " beat addr"}, 128'(mm_bus.mm_addr), 128'(e.addr));
                    if (e.is_write) begin
                        checkOutput({name, " beat wdata"}, 128'(mm_bus.mm_wdata), 128'(e.data));
                    end
                end
                if (mm_bus.mm_write) mem_store[mm_bus.mm_addr] = mm_bus.mm_wdata;
            end
        end
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic applyStimulus(input vec_t v);
        int cycles;
        int strobe_cnt;
        int exp_cycles;
        addr_to_mem     = v.addr;
        data_to_mem     = v.wdata;
        mem_read_index  = v.rd;
        mem_write_index = v.wr;
        #1;
        checkOutput({v.name, " first stall"}, 128'(stall_level_2),
                    128'(v.rd ? v.exp_miss : v.wr));
        if (v.rd) begin
            exp_cycles = v.exp_miss ? 1 + 4 * (v.wait_cyc + 1) : 0;
            if (v.exp_miss)
                for (int k = 0; k < 4; k++)
                    exp_q.push_back('{1'b0, {v.addr[31:2], 2'(k)}, 32'h0});
        end else if (v.wr) begin
            exp_cycles = 1 + (v.wait_cyc + 1);
            exp_q.push_back('{1'b1, v.addr, v.wdata});
        end else begin
            exp_cycles = 0;
        end
        cycles     = 0;
        strobe_cnt = 0;
        while (stall_level_2 && cycles < BUDGET) begin
            cycles++;
            if (v.drop_early && cycles == 2) begin
                mem_read_index  = 1'b0;
                mem_write_index = 1'b0;
            end
            serveMemory(v.name, v.wait_cyc, strobe_cnt);
            @(negedge clk); #1;
        end
        mm_bus.mm_ready = 1'b0;
        checkOutput({v.name, " stall cycles"}, 128'(cycles), 128'(exp_cycles));
        if (v.check_block)
            checkOutput({v.name, " block"}, block_of_data_from_cache_level_2, v.exp_block);
        checkOutput({v.name, " beats left"}, 128'(exp_q.size()), 128'd0);
        exp_q.delete();
        mem_read_index  = 1'b0;
        mem_write_index = 1'b0;
        @(negedge clk); #1;
        checkOutput({v.name, " idle strobes"},
                    128'({stall_level_2, mm_bus.mm_read, mm_bus.mm_write}), 128'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [127:0] blk40, blk40w, blk400, blk400w, blk140, blk280;
        int beats;
        bit done;

        blk40   = 128'h00000013_00000012_00000011_00000010;
        blk40w  = 128'h00000013_DEADBEEF_00000011_00000010;
        blk400  = 128'h00000453_00000452_00000451_12345678;
        blk400w = 128'h00000453_00000452_CAFEF00D_12345678;
        blk140  = 128'h00000113_00000112_00000111_00000110;
        blk280  = 128'h000002D3_000002D2_000002D1_000002D0;

        vecs.push_back(mk("rd40 miss",     32'h40,  0,            1, 0, 0, 1, 0, 1, blk40));
        vecs.push_back(mk("rd41 hit",      32'h41,  0,            1, 0, 0, 0, 0, 1, blk40));
        vecs.push_back(mk("wr42 hit",      32'h42,  32'hDEADBEEF, 0, 1, 2, 0, 0, 1, blk40w));
        vecs.push_back(mk("rd40 after wr", 32'h40,  0,            1, 0, 0, 0, 0, 1, blk40w));
        vecs.push_back(mk("wr400 miss",    32'h400, 32'h12345678, 0, 1, 0, 0, 0, 0, '0));
        vecs.push_back(mk("rd400 miss",    32'h400, 0,            1, 0, 0, 1, 0, 1, blk400));
        vecs.push_back(mk("rd140 slow",    32'h140, 0,            1, 0, 1, 1, 0, 1, blk140));
        vecs.push_back(mk("rd40 evicted",  32'h40,  0,            1, 0, 0, 1, 0, 1, blk40w));
        vecs.push_back(mk("rd140 again",   32'h140, 0,            1, 0, 0, 1, 0, 1, blk140));
        vecs.push_back(mk("rd402 hit",     32'h402, 0,            1, 0, 0, 0, 0, 1, blk400));
        vecs.push_back(mk("wr401 hit",     32'h401, 32'hCAFEF00D, 0, 1, 1, 0, 0, 1, blk400w));
        vecs.push_back(mk("rd+wr prio",    32'h403, 32'hBAD0BAD0, 1, 1, 0, 0, 0, 1, blk400w));
        vecs.push_back(mk("rd280 dropped", 32'h280, 0,            1, 0, 0, 1, 1, 1, blk280));
        vecs.push_back(mk("rd281 hit",     32'h281, 0,            1, 0, 0, 0, 0, 1, blk280));

        rst             = 1'b0;
        addr_to_mem     = '0;
        data_to_mem     = '0;
        mem_read_index  = 1'b0;
        mem_write_index = 1'b0;
        mm_bus.mm_ready = 1'b0;
        mm_bus.mm_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset outputs",
                    {94'd0, stall_level_2, mm_bus.mm_read, mm_bus.mm_write,
                     mm_bus.mm_addr, mm_bus.mm_wdata}, 128'd0);
        rst = 1'b1;
        @(negedge clk); #1;
        checkOutput("idle after reset",
                    128'({stall_level_2, mm_bus.mm_read, mm_bus.mm_write}), 128'd0);

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

        // Reset lands while the second refill beat is on the bus.
        addr_to_mem    = 32'h40;
        mem_read_index = 1'b1;
        beats = 0;
        done  = 1'b0;
        for (int c = 0; c < BUDGET && !done; c++) begin
            mm_bus.mm_ready = 1'b0;
            if (mm_bus.mm_read) begin
                beats++;
                if (beats == 2) begin
                    rst = 1'b0;
                    #1;
                    checkOutput("reset mid-fill strobes",
                                {94'd0, mm_bus.mm_read, mm_bus.mm_write, mm_bus.mm_addr,
                                 32'd0}, 128'd0);
                    done = 1'b1;
                end else begin
                    mm_bus.mm_ready = 1'b1;
                    mm_bus.mm_rdata = mem_rd(mm_bus.mm_addr);
                end
            end
            if (!done) begin
                @(negedge clk); #1;
            end
        end
        checkOutput("reset mid-fill reached", 128'(done), 128'd1);
        mm_bus.mm_ready = 1'b0;
        mem_read_index  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        @(negedge clk); #1;

        applyStimulus(mk("rd40 after rst",  32'h40,  0, 1, 0, 0, 1, 0, 1, blk40w));
        applyStimulus(mk("rd400 after rst", 32'h400, 0, 1, 0, 0, 1, 0, 1, blk400w));
        applyStimulus(mk("rd402 hit",       32'h402, 0, 1, 0, 0, 0, 0, 1, blk400w));
`ifdef L2_STATS_EN
        checkOutput("hit_count",  128'(hit_count),  128'd1);
        checkOutput("miss_count", 128'(miss_count), 128'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
